regfile_yw: RTL

//  Integer register file answering the decode stage's read requests (rs1/rs2 addresses
//  in, operand data out, same cycle) and taking writeback from the execute stage.

---
 rtl/regfile_yw.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/regfile_yw.sv
// regfile_yw - integer register file for the decode/execute pipeline.
//
// Purpose:
//   Two combinational read ports feed the decode stage. One write port takes
//   execute-stage writeback. A debug port with a req/ack handshake can read or
//   write any register without disturbing execute writeback. x0 reads as zero
//   and writes to it are dropped.
//
// Configuration macro:
//   REGFILE_BYPASS_EN - when defined, an execute write to the register being
//                       read is forwarded to that read port in the same cycle.
//                       When undefined, reads see array contents only.
//
// Ports:
//   clk          in   core clock, all state updates on the rising edge
//   rst          in   asynchronous reset, active-low
//   raddr1_i     in   read port 1 address
//   rdata1_o     out  read port 1 data (combinational)
//   raddr2_i     in   read port 2 address
//   rdata2_o     out  read port 2 data (combinational)
//   we_i         in   execute writeback enable
//   waddr_i      in   execute writeback address
//   wdata_i      in   execute writeback data
//   dbg_req_i    in   debug request, held high until dbg_ack_o is seen
//   dbg_we_i     in   debug access is a write
//   dbg_addr_i   in   debug register address
//   dbg_wdata_i  in   debug write data
//   dbg_rdata_o  out  debug read data, valid while dbg_ack_o is high
//   dbg_ack_o    out  debug access complete
module regfile_yw #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_ack_o
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } dbg_state_t;

    dbg_state_t        state_q;
    dbg_state_t        state_d;

    // x0 has no storage; entries 1..NREG-1 only.
    logic [DATA_W-1:0] regs_q [1:NREG-1];

    logic              lat_we_q;
    logic [ADDR_W-1:0] lat_addr_q;
    logic [DATA_W-1:0] lat_wdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;

    logic              exec_wr;
    logic              latch_req;
    logic              dbg_wr;
    logic              dbg_rd;
    logic [DATA_W-1:0] dbg_rd_value;

    function automatic logic [DATA_W-1:0] array_read(input logic [ADDR_W-1:0] addr);
        if (addr == '0) begin
            return '0;
        end
        return regs_q[addr];
    endfunction

    assign exec_wr = we_i && (waddr_i != '0);

`ifdef REGFILE_BYPASS_EN
    // exec_wr already excludes x0, so forwarding never makes x0 non-zero.
    assign rdata1_o = (exec_wr && (waddr_i == raddr1_i)) ? wdata_i : array_read(raddr1_i);
    assign rdata2_o = (exec_wr && (waddr_i == raddr2_i)) ? wdata_i : array_read(raddr2_i);
`else
    assign rdata1_o = array_read(raddr1_i);
    assign rdata2_o = array_read(raddr2_i);
`endif

    // A debug read returns the value the register holds after this edge,
    // so a same-cycle execute write to that register wins.
    assign dbg_rd_value = (exec_wr && (waddr_i == lat_addr_q)) ? wdata_i
                                                                : array_read(lat_addr_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A debug write waits in ACCESS while execute is writing, so the two
    // write sources never compete for the array in the same cycle.
    always_comb begin
        state_d   = state_q;
        latch_req = 1'b0;
        dbg_wr    = 1'b0;
        dbg_rd    = 1'b0;
        case (state_q)
            IDLE: begin
                if (dbg_req_i) begin
                    latch_req = 1'b1;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                if (!(lat_we_q && we_i)) begin
                    state_d = DONE;
                    if (lat_we_q) begin
                        dbg_wr = (lat_addr_q != '0);
                    end else begin
                        dbg_rd = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!dbg_req_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Debug request fields are captured once, so later changes on the
    // dbg_* inputs have no effect until the FSM is back in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            if (latch_req) begin
                lat_we_q    <= dbg_we_i;
                lat_addr_q  <= dbg_addr_i;
                lat_wdata_q <= dbg_wdata_i;
            end
            if (dbg_rd) begin
                dbg_rdata_q <= dbg_rd_value;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (exec_wr) begin
            regs_q[waddr_i] <= wdata_i;
        end else if (dbg_wr) begin
            regs_q[lat_addr_q] <= lat_wdata_q;
        end
    end

    assign dbg_ack_o   = (state_q == DONE);
    assign dbg_rdata_o = dbg_rdata_q;

endmodule
